// File: rtl/bit_serial_adder.sv
// ---------------------------------------------------------------------------
// bit_serial_adder
//
// Multi-cycle word adder that resolves one bit per clock, LSB first, through
// a single full-adder slice. A carry register links each bit to the next.
// Acts as a sequential reference for the combinational carry netlist that
// sits downstream of it.
//
// Build option:
//   BIT_SERIAL_ADDER_SUB_EN  adds in_sub; when set on the acceptance edge
//                            the block computes in_a - in_b (out_co=1 means
//                            no borrow). Without the macro: addition only.
//
// Parameters:
//   WIDTH  operand/sum width, 1..64
//   CNT_W  bit-counter width (derived, do not override)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand word offered
//   in_ready   block can accept an operand word (IDLE)
//   in_a/in_b  operands
//   in_ci      carry-in for bit 0
//   in_sub     (optional) subtract request, sampled on acceptance
//   out_valid  result held and valid (DONE)
//   out_ready  consumer accepts result
//   out_sum    sum word
//   out_co     carry-out of bit WIDTH-1
//   busy       high while bits are being resolved (RUN)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_valid may be held while in_ready is low; it is simply not
// seen. out_sum/out_co are held stable for as long as out_valid is high and
// out_ready is low. The three FSM states are fully observable on
// in_ready (IDLE), busy (RUN) and out_valid (DONE).
// ---------------------------------------------------------------------------
module bit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
`ifdef BIT_SERIAL_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] count;

    logic             slice_s;
    logic             slice_co;
    logic [WIDTH-1:0] sum_shift;
    logic [WIDTH-1:0] cap_b;
    logic             cap_ci;

    // Operand conditioning at capture. Subtraction is a + ~b + 1.
`ifdef BIT_SERIAL_ADDER_SUB_EN
    assign cap_b  = in_sub ? ~in_b : in_b;
    assign cap_ci = in_sub ? 1'b1  : in_ci;
`else
    assign cap_b  = in_b;
    assign cap_ci = in_ci;
`endif

    // Single full-adder slice plus the sum shift. Built as shift-then-insert
    // so that WIDTH=1 needs no special case.
    always_comb begin
        slice_s   = a_sr[0] ^ b_sr[0] ^ carry;
        slice_co  = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        sum_shift = sum_sr >> 1;
        sum_shift[WIDTH-1] = slice_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)          state_next = RUN;
            RUN:  if (count == LAST_BIT) state_next = DONE;
            DONE: if (out_ready)         state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // Datapath. Operands are only sampled on the acceptance edge, so
    // whatever sits on in_a/in_b at other times never reaches state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_sr  <= in_a;
                b_sr  <= cap_b;
                carry <= cap_ci;
                count <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                sum_sr <= sum_shift;
                carry  <= slice_co;
                count  <= count + CNT_W'(1);
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);
    assign out_sum   = sum_sr;
    assign out_co    = carry;

endmodule

// File: tb/tb_bit_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_adder
//
// Drives an 8-bit and a 1-bit instance of bit_serial_adder. Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bit_serial_adder;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    // 8-bit instance
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_ci;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_co;
    logic       busy;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    logic       in_sub;
    logic       w1_in_sub;
`endif

    // 1-bit instance
    logic       w1_in_valid;
    logic       w1_in_ready;
    logic [0:0] w1_in_a;
    logic [0:0] w1_in_b;
    logic       w1_in_ci;
    logic       w1_out_valid;
    logic       w1_out_ready;
    logic [0:0] w1_out_sum;
    logic       w1_out_co;
    logic       w1_busy;

    // Scoreboards: {co, sum}
    logic [8:0] exp_q[$];
    logic [1:0] exp1_q[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] sum;
        logic       co;
    } vec8_t;

    typedef struct {
        logic a;
        logic b;
        logic ci;
        logic sum;
        logic co;
    } vec1_t;

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
`ifdef BIT_SERIAL_ADDER_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co),
        .busy      (busy)
    );

    bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w1_in_valid),
        .in_ready  (w1_in_ready),
        .in_a      (w1_in_a),
        .in_b      (w1_in_b),
        .in_ci     (w1_in_ci),
`ifdef BIT_SERIAL_ADDER_SUB_EN
        .in_sub    (w1_in_sub),
`endif
        .out_valid (w1_out_valid),
        .out_ready (w1_out_ready),
        .out_sum   (w1_out_sum),
        .out_co    (w1_out_co),
        .busy      (w1_busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"},  64'(in_ready),  64'd1);
        check({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " out_sum"},   64'(out_sum),   64'd0);
        check({tag, " out_co"},    64'(out_co),    64'd0);
        check({tag, " busy"},      64'(busy),      64'd0);
    endtask

    // ---------------- driver: one full 8-bit operation ----------------
    // Offers the operands, pushes the expected result at acceptance, then
    // measures latency / busy duration and compares the popped result.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic [8:0] exp);
        int         lat;
        int         busy_n;
        logic [8:0] e;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_ci    = ci;
        check({name, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        exp_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 'x;
        in_b     = 'x;
        lat      = 0;
        busy_n   = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_n++;
            lat++;
            @(negedge clk);
        end
        check({name, " out_valid"}, 64'(out_valid), 64'd1);
        check({name, " latency"},   64'(lat),       64'd8);
        check({name, " busy_cycles"}, 64'(busy_n),  64'd8);
        e = exp_q.pop_front();
        check({name, " out_sum"}, 64'(out_sum), 64'(e[7:0]));
        check({name, " out_co"},  64'(out_co),  64'(e[8]));
        in_a = 8'h00;
        in_b = 8'h00;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec8_t      tbl[7];
        vec1_t      tbl1[4];
        logic [8:0] e;
        logic [1:0] e1;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rci;
        int         wait_n;
        int         pulses;
        int         acc;
        int         prev_acc;

        checks   = 0;
        failures = 0;

        tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        tbl[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        tbl[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

        tbl1[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl1[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl1[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst          = 1'b1;
        in_valid     = 1'b0;
        in_a         = 8'h00;
        in_b         = 8'h00;
        in_ci        = 1'b0;
        out_ready    = 1'b1;
        w1_in_valid  = 1'b0;
        w1_in_a      = 1'b0;
        w1_in_b      = 1'b0;
        w1_in_ci     = 1'b0;
        w1_out_ready = 1'b1;
`ifdef BIT_SERIAL_ADDER_SUB_EN
        in_sub       = 1'b0;
        w1_in_sub    = 1'b0;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci,
                   {tbl[i].co, tbl[i].sum});
        end

        // Random vectors against an arithmetic model
        for (int i = 0; i < 6; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rci = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), ra, rb, rci,
                   {1'b0, ra} + {1'b0, rb} + {8'h00, rci});
        end

        // Backpressure in DONE: result held, second offer ignored
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'h33;
        in_b      = 8'h11;
        in_ci     = 1'b0;
        @(posedge clk);
        exp_q.push_back({1'b0, 8'h44});
        @(negedge clk);
        in_valid = 1'b0;
        wait_n   = 0;
        while (!out_valid && wait_n < 40) begin
            wait_n++;
            @(negedge clk);
        end
        check("bp out_valid", 64'(out_valid), 64'd1);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = 8'hAA;
            in_b     = 8'h55;
            in_ci    = 1'b1;
            @(negedge clk);
            check($sformatf("bp hold%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("bp hold%0d in_ready", i),  64'(in_ready),  64'd0);
            check($sformatf("bp hold%0d out_sum", i),   64'(out_sum),   64'(e[7:0]));
            check($sformatf("bp hold%0d out_co", i),    64'(out_co),    64'(e[8]));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release out_valid", 64'(out_valid), 64'd0);
        check("bp release in_ready",  64'(in_ready),  64'd1);
        run_op("bp next", 8'h01, 8'h01, 1'b0, {1'b0, 8'h02});

        // Reset during RUN: discarded, no out_valid pulse
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 8'h0F;
        in_b     = 8'h0E;
        in_ci    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid-run busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid-run rst");
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("mid-run no out_valid", 64'(pulses), 64'd0);
        check("mid-run idle", 64'(in_ready), 64'd1);
        run_op("post-rst", 8'h02, 8'h03, 1'b0, {1'b0, 8'h05});

`ifdef BIT_SERIAL_ADDER_SUB_EN
        in_sub = 1'b1;
        run_op("sub 5-7", 8'h05, 8'h07, 1'b0, {1'b0, 8'hFE});
        run_op("sub 7-5", 8'h07, 8'h05, 1'b0, {1'b1, 8'h02});
        in_sub = 1'b0;
        run_op("sub off", 8'h07, 8'h05, 1'b0, {1'b0, 8'h0C});
`endif

        // WIDTH=1: back-to-back with in_valid held high, 3-cycle interval
        @(negedge clk);
        w1_in_valid = 1'b1;
        prev_acc    = 0;
        for (int i = 0; i < 4; i++) begin
            w1_in_a  = tbl1[i].a;
            w1_in_b  = tbl1[i].b;
            w1_in_ci = tbl1[i].ci;
            wait_n   = 0;
            while (!w1_in_ready && wait_n < 10) begin
                wait_n++;
                @(negedge clk);
            end
            check($sformatf("w1 op%0d in_ready", i), 64'(w1_in_ready), 64'd1);
            acc = cyc + 1;
            if (i > 0) check($sformatf("w1 op%0d interval", i), 64'(acc - prev_acc), 64'd3);
            prev_acc = acc;
            exp1_q.push_back({tbl1[i].co, tbl1[i].sum});
            @(negedge clk);
            check($sformatf("w1 op%0d busy", i),      64'(w1_busy),      64'd1);
            check($sformatf("w1 op%0d early valid", i), 64'(w1_out_valid), 64'd0);
            @(negedge clk);
            check($sformatf("w1 op%0d out_valid", i), 64'(w1_out_valid), 64'd1);
            e1 = exp1_q.pop_front();
            check($sformatf("w1 op%0d out_sum", i), 64'(w1_out_sum), 64'(e1[0]));
            check($sformatf("w1 op%0d out_co", i),  64'(w1_out_co),  64'(e1[1]));
        end
        w1_in_valid = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard empty", 64'(exp_q.size() + exp1_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Multi-cycle word adder that resolves one bit per clock, LSB first.
- Each cycle uses a single full-adder slice: sum = a^b^c, carry-out = majority(a,b,c).
- A carry register links one bit to the next.
- Sits directly upstream of the flat XOR/XNOR and full-adder carry netlist block. It produces the registered sum word and carry-out that the netlist stage consumes, and gives a sequential reference for equivalence against the combinational carry cells.

Parameters:
- WIDTH, 8: operand and sum width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH)+1: bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous assert, active-high; synchronous deassert is the integrator's responsibility.
- in_valid  input  1  operand word offered.
- in_ready  output  1  block can accept an operand word.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_ci  input  1  carry-in for bit 0.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  sum word.
- out_co  output  1  carry-out of bit WIDTH-1.
- busy  output  1  high in RUN state.

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE, carry=0, bit counter=0, shift registers=0. Outputs: in_ready=1, out_valid=0, out_sum=0, out_co=0, busy=0.
- States are IDLE, RUN and DONE. in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state==RUN).
- IDLE: on an edge with in_valid&&in_ready:
  - capture in_a and in_b into shift registers;
  - carry <= in_ci; count <= 0;
  - go to RUN.
  - Operand inputs are ignored at all other times.
- RUN, each edge:
  - s = a_sr[0]^b_sr[0]^carry;
  - carry <= (a_sr[0]&b_sr[0]) | (a_sr[0]&carry) | (b_sr[0]&carry);
  - a_sr and b_sr shift right by one;
  - sum_sr <= {s, sum_sr[WIDTH-1:1]};
  - count <= count+1.
  - When count==WIDTH-1, go to DONE on that same edge.
- DONE:
  - out_sum = sum_sr; out_co = carry.
  - Both are stable while out_valid=1 and out_ready=0, for any number of cycles.
  - On an edge with out_ready=1, go to IDLE.
  - out_sum and out_co keep their last values in IDLE; they are only meaningful while out_valid=1.
- Latency: acceptance edge at cycle 0 gives out_valid=1 after edge WIDTH.
- Minimum initiation interval is WIDTH+2 cycles. A new operand is accepted no earlier than the edge after DONE→IDLE.
- WIDTH=1: RUN lasts exactly one cycle; the count compare is against 0.
- Arithmetic: modulo 2^WIDTH, with out_co as the true carry.
  - Maximum case: all-ones + all-ones + ci=1 gives out_sum=all-ones, out_co=1.
- in_valid asserted while not in IDLE: no effect, no capture, no error. Upstream must hold in_valid until in_ready.
- out_ready asserted outside DONE: ignored.
- rst asserted mid-RUN or in DONE: immediate return to reset values. The in-flight operation is discarded and no out_valid pulse is produced.
- No X propagation: all registers are reset. X on in_a or in_b outside the capture edge must not reach state.

Optional Feature:
- Macro: BIT_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port in_sub (1 bit), sampled on the acceptance edge.
  - in_sub=1 captures ~in_b instead of in_b and forces carry <= 1, ignoring in_ci. The result is in_a - in_b mod 2^WIDTH.
  - out_co=1 means no borrow.
  - in_sub=0 behaves exactly as without the macro.
- Undefined: port absent; addition only.

Test Plan:
- WIDTH=8, a=0x0F, b=0x01, ci=0, out_ready=1 → out_valid after 8 cycles, out_sum=0x10, out_co=0, busy high for exactly 8 cycles.
- a=0xFF, b=0xFF, ci=1 → out_sum=0xFF, out_co=1. Also a=0xFF, b=0x01, ci=0 → out_sum=0x00, out_co=1.
- out_ready held 0 for 5 cycles in DONE → out_sum/out_co stable, in_ready=0, and a second in_valid pulse is not captured. Then out_ready=1 → IDLE, next word accepted.
- Assert rst at cycle 3 of RUN → all outputs return to reset values immediately, out_valid never pulses. After release, a=0x02, b=0x03 → out_sum=0x05, out_co=0.
- WIDTH=1, a=1, b=1, ci=1 → out_valid after 1 cycle, out_sum=1, out_co=1. Back-to-back ops spaced exactly 3 cycles apart.
- With BIT_SERIAL_ADDER_SUB_EN: in_sub=1, a=0x05, b=0x07 → out_sum=0xFE, out_co=0. Then a=0x07, b=0x05 → out_sum=0x02, out_co=1.
